// File: rtl/wb_commit_queue.sv
// Write-back commit queue: in-order buffer of completed results draining into the register
// file, with a pending-write mask and youngest-match forwarding lookup for decode.
module wb_commit_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [REG_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [REG_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    mem_ready,
    output logic                    wb_valid,
    output logic [REG_W-1:0]        wb_dest,
    output logic [DATA_W-1:0]       wb_data,
    input  logic                    wb_ready,
    output logic [2**REG_W-1:0]     busy_mask,
    input  logic [REG_W-1:0]        lookup_reg,
    output logic                    lookup_hit,
    output logic [DATA_W-1:0]       lookup_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REG_W-1:0]  ent_dest [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     slot;

    logic              pop;
    logic              push_allowed;
    logic              mem_fire;
    logic              alu_fire;
    logic              push;
    logic [REG_W-1:0]  push_dest;
    logic [DATA_W-1:0] push_data;

    assign wb_valid = (count != '0);
    assign wb_dest  = ent_dest[rd_ptr];
    assign wb_data  = ent_data[rd_ptr];
    assign pop      = wb_valid && wb_ready;

    // A slot freed by this cycle's drain can be refilled on the same edge.
    assign push_allowed = (count < FULL_CNT) || pop;
    assign mem_ready    = reset && push_allowed;
    assign alu_ready    = reset && push_allowed && !mem_valid;
    assign mem_fire     = mem_valid && mem_ready;
    assign alu_fire     = alu_valid && alu_ready;

    // Writes to x0 complete their handshake but never occupy a slot.
    assign push      = (mem_fire && (mem_dest != '0)) || (alu_fire && (alu_dest != '0));
    assign push_dest = mem_fire ? mem_dest : alu_dest;
    assign push_data = mem_fire ? mem_data : alu_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: payload storage is deliberately unreset; valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_dest[wr_ptr] <= push_dest;
            ent_data[wr_ptr] <= push_data;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy_mask[ent_dest[i]] = 1'b1;
            end
        end
    end

    // Valid entries are contiguous from rd_ptr, so scanning oldest-to-youngest and keeping
    // the last match yields the youngest one.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if (ent_valid[slot] && (ent_dest[slot] == lookup_reg) && (lookup_reg != '0)) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[slot];
            end
        end
    end
endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Write-back commit queue between the ALU/data-memory result sources and the register file unit's write port.
- Buffers completed results in a small in-order FIFO and drains one entry per cycle into the register file as a destination index and data pair.
- Exports a pending-write mask and a youngest-match forwarding lookup so decode can resolve RAW hazards against results not yet written.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- DATA_W, 32: result data width.
- REG_W, 5: register index width (32 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_dest  in  REG_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  load result offered.
- mem_dest  in  REG_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load result accepted this cycle.
- wb_valid  out  1  head entry presented to the register file.
- wb_dest  out  REG_W  head destination index.
- wb_data  out  DATA_W  head data.
- wb_ready  in  1  register file consumes the head this cycle.
- busy_mask  out  2**REG_W  bit r is set while any valid entry targets register r.
- lookup_reg  in  REG_W  forwarding query index.
- lookup_hit  out  1  some valid entry targets lookup_reg.
- lookup_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of valid entries.

Behaviour:
- **Reset (reset low, asynchronous):**
  - rd_ptr, wr_ptr and count are 0; all entry valid bits are 0.
  - All outputs are 0: wb_valid=0, busy_mask=0, lookup_hit=0, lookup_data=0, alu_ready=0, mem_ready=0.
  - Entry contents are don't-care.
  - Reset asserted mid-drain discards all entries. There is no partial write: wb_valid drops asynchronously.
- **Acceptance:**
  - full means count==DEPTH.
  - Once count reflects the current drain decision, the slot it frees is usable in the same cycle.
  - A push is allowed if count<DEPTH, or if count==DEPTH and a pop occurs this cycle.
  - Both ready outputs are low while reset is asserted.
- **Source priority:**
  - At most one enqueue per cycle.
  - mem has priority: mem_ready = push-allowed.
  - alu_ready = push-allowed AND NOT mem_valid.
  - A handshake completes when valid and ready are both high at the clock edge.
- **Register x0:**
  - A handshake whose dest==0 completes with ready high but is not enqueued.
  - It does not change pointers, count or busy_mask.
- **Enqueue:** writes {dest, data, valid=1} at wr_ptr, then wr_ptr+1 modulo DEPTH.
- **Drain:**
  - wb_valid = (count!=0); wb_dest and wb_data come from the rd_ptr entry and are driven combinationally from storage.
  - On wb_valid && wb_ready: clear that entry's valid bit, rd_ptr+1 modulo DEPTH.
  - Head data must stay stable while wb_ready is low.
- **Latency:**
  - A result accepted at edge N is at the head and visible at wb_* from N+1 when the queue was empty.
  - There is no same-cycle bypass from input to wb_*.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. This is legal when full and when count==1.
- **count:** count+1 on push only, count-1 on pop only; it never exceeds DEPTH and never underflows.
- **busy_mask:**
  - Combinational OR over valid entries of onehot(dest).
  - A bit clears in the cycle after its last matching entry pops.
- **Forwarding lookup:**
  - Combinational.
  - Scan from the youngest entry (wr_ptr-1) back to rd_ptr; the first valid match wins.
  - lookup_reg==0 always gives hit=0, data=0.
- **Wrap-around:** pointers are clog2(DEPTH) bits and wrap naturally; full/empty are decided by count, not by pointer comparison.
- **Ordering:** entries drain strictly in acceptance order. Two writes to the same register reach the register file oldest first.

Test Plan:
1. **Reset state:** reset low while alu_valid=1, alu_dest=3 → alu_ready=0, wb_valid=0, busy_mask=0, count=0. After release, alu_valid=1, dest=3, data=0xA5 at edge N → wb_valid=1, wb_dest=3, wb_data=0xA5 at N+1 and busy_mask[3]=1. With wb_ready=1 → busy_mask=0 at N+2.
2. **Fill and drain order:** wb_ready=0, push ALU dests 1,2,3,4 with data 0x11..0x44 → count=4, alu_ready=0, mem_ready=0. Then wb_ready=1 for 4 cycles → wb_dest sequence 1,2,3,4 with matching data, then count=0.
3. **Source priority:** both valid in one cycle (mem dest 5 data 0x55, alu dest 6 data 0x66) → mem accepted, alu_ready=0. The next cycle, with mem_valid low, accepts alu → drain order 5 then 6.
4. **Full with concurrent pop:** queue full and wb_ready=1, push dest 7 data 0x77 → both handshakes complete, count stays 4. 0x77 drains fourth, which covers wr_ptr wrap.
5. **Youngest-match forwarding:** push dest 9 data 0x90, then dest 9 data 0x91, with wb_ready=0; lookup_reg=9 → hit=1, data=0x91. After one pop, lookup_data is still 0x91; after the second pop, hit=0 and busy_mask[9]=0.
6. **x0 write and async reset mid-drain:** alu dest 0 data 0xFF → alu_ready=1, count unchanged. Then with 3 entries queued, pulse reset low mid-cycle → wb_valid drops immediately; after release count=0 and busy_mask=0.
